// File: rtl/sequence_detector_param.sv
// Serial pattern detector: runtime pattern, overlap/non-overlap
// matching, Mealy and Moore hit outputs, saturating hit counter.
module sequence_detector_param #(
  parameter int WIDTH = 4,
  parameter int COUNT_WIDTH = 8,
  parameter logic [WIDTH-1:0] PATTERN_INIT = WIDTH'(4'b1011)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   a,
  input  logic                   overlap,
  input  logic                   clear,
  input  logic                   pattern_load,
  input  logic [WIDTH-1:0]       pattern,
  output logic                   match_mealy,
  output logic                   match_moore,
  output logic [COUNT_WIDTH-1:0] match_count,
  output logic [WIDTH-1:0]       history,
  output logic                   armed
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(WIDTH);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    ARMED
  } fill_e;

  logic [WIDTH-1:0]       r_pat;
  logic [WIDTH-1:0]       r_hist;
  logic [FW-1:0]          r_fill;
  logic                   r_moore;
  logic [COUNT_WIDTH-1:0] r_count;

  logic [WIDTH-1:0]       w_pat_n;
  logic [WIDTH-1:0]       w_hist_n;
  logic [FW-1:0]          w_fill_n;
  logic                   w_moore_n;
  logic [COUNT_WIDTH-1:0] w_count_n;

  logic [WIDTH-1:0]       w_cand;
  logic [FW-1:0]          w_cand_fill;
  logic                   w_hit;
  fill_e                  w_fstate;

  assign w_cand      = {r_hist[WIDTH-2:0], a};
  assign w_cand_fill = (r_fill == FULL) ? FULL
                     : r_fill + FW'(1);

  // Load and clear both invalidate history, so they block a hit.
  assign w_hit = enable & ~clear & ~pattern_load
               & (w_cand_fill == FULL)
               & (w_cand == r_pat);

  always_comb begin
    w_fstate = EMPTY;
    if (r_fill == FULL)
      w_fstate = ARMED;
    else if (r_fill != '0)
      w_fstate = FILLING;
  end

  always_comb begin
    w_pat_n   = r_pat;
    w_hist_n  = r_hist;
    w_fill_n  = r_fill;
    w_moore_n = 1'b0;
    w_count_n = r_count;
    if (clear) begin
      w_hist_n  = '0;
      w_fill_n  = '0;
      w_count_n = '0;
    end else if (pattern_load) begin
      w_pat_n  = pattern;
      w_fill_n = '0;
    end else if (enable) begin
      w_hist_n  = w_cand;
      w_moore_n = w_hit;
      if (w_hit && (r_count != '1))
        w_count_n = r_count + COUNT_WIDTH'(1);
      if (w_hit && !overlap)
        w_fill_n = '0;
      else
        w_fill_n = w_cand_fill;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pat   <= PATTERN_INIT;
      r_hist  <= '0;
      r_fill  <= '0;
      r_moore <= 1'b0;
      r_count <= '0;
    end else begin
      r_pat   <= w_pat_n;
      r_hist  <= w_hist_n;
      r_fill  <= w_fill_n;
      r_moore <= w_moore_n;
      r_count <= w_count_n;
    end
  end

  assign match_mealy = w_hit & reset_n;
  assign match_moore = r_moore;
  assign match_count = r_count;
  assign history     = r_hist;
  assign armed       = (w_fstate == ARMED);

endmodule

// File: tb/tb_sequence_detector_param.sv
// Bench for sequence_detector_param: queue-based reference model
// checked every cycle, plus directed literal expectations.
module tb_sequence_detector_param;

  localparam int W = 4;

  logic         clock;
  logic         reset_n;
  logic         enable;
  logic         a;
  logic         overlap;
  logic         clear;
  logic         pattern_load;
  logic [W-1:0] pattern;

  logic         mealy_d;
  logic         moore_d;
  logic [7:0]   count_d;
  logic [W-1:0] hist_d;
  logic         armed_d;

  logic         mealy_s;
  logic         moore_s;
  logic [1:0]   count_s;
  logic [W-1:0] hist_s;
  logic         armed_s;

  sequence_detector_param #(
    .WIDTH(4), .COUNT_WIDTH(8)
  ) u_dut (
    .clock(clock), .reset_n(reset_n),
    .enable(enable), .a(a),
    .overlap(overlap), .clear(clear),
    .pattern_load(pattern_load),
    .pattern(pattern),
    .match_mealy(mealy_d),
    .match_moore(moore_d),
    .match_count(count_d),
    .history(hist_d),
    .armed(armed_d)
  );

  sequence_detector_param #(
    .WIDTH(4), .COUNT_WIDTH(2)
  ) u_sat (
    .clock(clock), .reset_n(reset_n),
    .enable(enable), .a(a),
    .overlap(overlap), .clear(clear),
    .pattern_load(pattern_load),
    .pattern(pattern),
    .match_mealy(mealy_s),
    .match_moore(moore_s),
    .match_count(count_s),
    .history(hist_s),
    .armed(armed_s)
  );

  int tests = 0;
  int fails = 0;
  logic last_mealy;

  task automatic chk(input string name,
                     input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, got, exp);
    end
  endtask

  // Reference model: samples since last clear (for history),
  // count of samples toward the next match, unbounded hit total.
  bit           q_all[$];
  int           m_valid = 0;
  logic [W-1:0] m_pat = 4'b1011;
  int           m_hits = 0;
  bit           m_moore = 0;

  function automatic logic [W-1:0] win(input bit s[$]);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W && i < s.size(); i++)
      w[i] = s[s.size()-1-i];
    return w;
  endfunction

  function automatic bit m_hit();
    bit t[$];
    t = q_all;
    t.push_back(a);
    return reset_n && enable && !clear && !pattern_load
        && (m_valid + 1 >= W) && (win(t) == m_pat);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  initial begin
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        q_all.delete();
        m_valid = 0;
        m_pat = 4'b1011;
        m_hits = 0;
        m_moore = 0;
      end else if (clear) begin
        q_all.delete();
        m_valid = 0;
        m_hits = 0;
        m_moore = 0;
      end else if (pattern_load) begin
        m_pat = pattern;
        m_valid = 0;
        m_moore = 0;
      end else if (enable) begin
        bit h;
        h = m_hit();
        q_all.push_back(a);
        if (q_all.size() > W) void'(q_all.pop_front());
        m_hits += int'(h);
        m_moore = h;
        m_valid = (h && !overlap) ? 0 : m_valid + 1;
      end else begin
        m_moore = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("mdl_mealy", int'(mealy_d), int'(m_hit()));
      chk("mdl_moore", int'(moore_d), int'(m_moore));
      chk("mdl_count", int'(count_d), sat(m_hits, 255));
      chk("mdl_hist", int'(hist_d), int'(win(q_all)));
      chk("mdl_armed", int'(armed_d), int'(m_valid >= W));
      chk("mdl_sat_cnt", int'(count_s), sat(m_hits, 3));
      chk("mdl_sat_mealy", int'(mealy_s), int'(m_hit()));
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input bit en, input bit av,
                      input bit ov, input bit clr = 1'b0,
                      input bit ld = 1'b0,
                      input logic [W-1:0] pv = '0);
    enable = en;
    a = av;
    overlap = ov;
    clear = clr;
    pattern_load = ld;
    pattern = pv;
    @(negedge clock);
    #1;
    last_mealy = mealy_d;
    @(posedge clock);
    #1;
  endtask

  bit s1[7] = '{1, 0, 1, 1, 0, 1, 1};
  int mp;

  initial begin
    reset_n = 1'b1;
    enable = 0; a = 0; overlap = 1;
    clear = 0; pattern_load = 0; pattern = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hist", int'(hist_d), 0);
    chk("rst_count", int'(count_d), 0);
    chk("rst_moore", int'(moore_d), 0);
    chk("rst_armed", int'(armed_d), 0);
    reset_n = 1'b1;

    // 1: overlapping, Moore lags Mealy by one cycle
    for (int i = 0; i < 7; i++) begin
      step(1, s1[i], 1);
      chk("t1_mealy", int'(last_mealy),
          int'(i == 3 || i == 6));
      chk("t1_moore", int'(moore_d),
          int'(i == 3 || i == 6));
    end
    chk("t1_count", int'(count_d), 2);
    chk("t1_sat", int'(count_s), 2);
    chk("t1_hist", int'(hist_d), 4'b1011);

    // 2: non-overlapping
    step(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step(1, s1[i], 0);
      chk("t2_mealy", int'(last_mealy), int'(i == 3));
      if (i == 3) chk("t2_armed_hit", int'(armed_d), 0);
    end
    chk("t2_armed_end", int'(armed_d), 0);
    chk("t2_count", int'(count_d), 1);

    // 3: enable gaps with a toggling
    step(0, 0, 1, 1);
    mp = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, s1[i], 1);
      mp += int'(last_mealy);
      for (int g = 0; g < 3; g++) begin
        step(0, g[0], 1);
        chk("t3_gap_mealy", int'(last_mealy), 0);
        chk("t3_gap_moore", int'(moore_d), 0);
      end
    end
    chk("t3_pulses", mp, 2);
    chk("t3_count", int'(count_d), 2);

    // 4: pattern load mid-stream
    step(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 1);
    chk("t4_armed", int'(armed_d), 1);
    step(1, 1, 1, 0, 1, 4'b0000);
    chk("t4_ld_mealy", int'(last_mealy), 0);
    chk("t4_ld_hist", int'(hist_d), 0);
    chk("t4_ld_armed", int'(armed_d), 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1);
      chk("t4_mealy", int'(last_mealy), int'(i == 3));
    end
    chk("t4_count", int'(count_d), 1);

    // 5: saturation of the 2-bit counter
    step(0, 0, 1, 1);
    step(0, 0, 1, 0, 1, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 1);
      chk("t5_mealy", int'(last_mealy), int'(i >= 3));
      chk("t5_moore", int'(moore_d), int'(i >= 3));
    end
    chk("t5_sat", int'(count_s), 3);
    chk("t5_count", int'(count_d), 7);
    step(0, 0, 1);
    chk("t5_moore_off", int'(moore_d), 0);
    chk("t5_sat_hold", int'(count_s), 3);

    // 6a: clear beats load and sample
    step(1, 1, 1, 1, 1, 4'b0000);
    chk("t6_clr_mealy", int'(last_mealy), 0);
    chk("t6_clr_count", int'(count_d), 0);
    chk("t6_clr_sat", int'(count_s), 0);
    chk("t6_clr_hist", int'(hist_d), 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1);
      chk("t6_pat_kept", int'(last_mealy), int'(i == 3));
    end

    // 6b: asynchronous reset between edges
    step(1, 1, 1);
    chk("t6_pre_moore", int'(moore_d), 1);
    chk("t6_pre_count", int'(count_d), 2);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_ar_mealy", int'(mealy_d), 0);
    chk("t6_ar_moore", int'(moore_d), 0);
    chk("t6_ar_count", int'(count_d), 0);
    chk("t6_ar_hist", int'(hist_d), 0);
    chk("t6_ar_armed", int'(armed_d), 0);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, s1[i], 1);
      chk("t6_resume", int'(last_mealy), int'(i == 3));
    end
    chk("t6_res_count", int'(count_d), 1);

    step(0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
